// File: rtl/tick_sample_pacer_pkg.sv
// Shared types and helpers for the tick-paced sample output stage.
package tick_sample_pacer_pkg;

    typedef enum logic {FILL, RUN} pacer_state_t;

    localparam int unsigned DW_DEFAULT         = 16;
    localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/tick_sample_pacer_fifo.sv
// Synchronous sample FIFO; the occupancy register is the only full/empty authority.
module sample_fifo #(
    parameter int unsigned DW         = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tick_sample_pacer.sv
// Tick-paced sample output stage: prefill, one sample per accepted tick, underrun re-priming.
// Define TICK_SAMPLE_PACER_ZERO_FILL_EN to output silence on underrun instead of holding.
module tick_sample_pacer
    import tick_sample_pacer_pkg::*;
#(
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int unsigned PREFILL    = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tick,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DW-1:0]         m_data,
    output logic                  m_strobe,
    output logic [DEPTH_LOG2:0]   level,
    output logic [CNT_W-1:0]      underrun_cnt,
    output logic                  running
);

    if (PREFILL == 0 || PREFILL > 2 ** DEPTH_LOG2) begin : g_prefill_check
        $error("tick_sample_pacer: PREFILL must be in 1..2**DEPTH_LOG2");
    end

    localparam logic [DEPTH_LOG2:0] PREFILL_L = (DEPTH_LOG2 + 1)'(PREFILL);

    pacer_state_t    state_q;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic            acc_tick;
    logic            fifo_pop;

    assign s_ready  = !fifo_full;
    assign acc_tick = tick && en;
    assign fifo_pop = (state_q == RUN) && acc_tick && !fifo_empty;

    sample_fifo #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (fifo_pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            m_data       <= '0;
            m_strobe     <= 1'b0;
            underrun_cnt <= '0;
            running      <= 1'b0;
        end else begin
            m_strobe <= 1'b0;
            case (state_q)
                FILL: begin
                    if (level >= PREFILL_L) begin
                        state_q <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (acc_tick) begin
                        // Strobe on every accepted tick so the sink cadence never slips.
                        m_strobe <= 1'b1;
                        if (!fifo_empty) begin
                            m_data <= fifo_rdata;
                        end else begin
                            underrun_cnt <= CNT_W'(sat_inc(64'(underrun_cnt), CNT_W));
`ifdef TICK_SAMPLE_PACER_ZERO_FILL_EN
                            m_data <= '0;
`else
                            m_data <= m_data;
`endif
                            state_q <= FILL;
                            running <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_sample_pacer.sv
// Scoreboarded directed bench for tick_sample_pacer (default parameters).
module tb_tick_sample_pacer;

`ifdef TICK_SAMPLE_PACER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_strobe;
    logic [4:0]  level;
    logic [15:0] underrun_cnt;
    logic        running;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    tick_sample_pacer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tick         (tick),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_strobe     (m_strobe),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .running      (running)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
    endtask

    // Issue one tick; if a strobe is expected its data goes to the scoreboard.
    task automatic tick_exp(input logic exp_strobe, input logic [15:0] exp_data);
        tick = 1'b1;
        if (exp_strobe) exp_q.push_back(exp_data);
        step(1);
        tick = 1'b0;
        chk("strobe_latency", 32'(m_strobe), 32'(exp_strobe));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        tick    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        fork
            forever begin
                @(negedge clk);
                if (m_strobe) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got m_data=%0h want no strobe", m_data);
                    end else begin
                        chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        step(2);
        chk("rst_level", 32'(level), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_strobe", 32'(m_strobe), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_underrun", 32'(underrun_cnt), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        rst = 1'b0;

        // Prefill: ticks during FILL are ignored
        for (int i = 1; i <= 7; i++) begin
            push(16'(i));
            tick_exp(1'b0, 16'h0);
            step(8);
        end
        chk("prefill_level", 32'(level), 7);
        chk("prefill_running", 32'(running), 0);
        push(16'h0008);
        step(1);
        chk("prefill_run", 32'(running), 1);

        for (int i = 9; i <= 16; i++) push(16'(i));
        chk("full_level", 32'(level), 16);
        chk("full_s_ready", 32'(s_ready), 0);

        // Full FIFO: push attempt with tick -> pop only
        s_data  = 16'h00AA;
        s_valid = 1'b1;
        tick_exp(1'b1, 16'h0001);
        s_valid = 1'b0;
        chk("full_pop_level", 32'(level), 15);
        chk("full_pop_s_ready", 32'(s_ready), 1);

        // Enable gating
        en = 1'b0;
        repeat (5) begin
            tick_exp(1'b0, 16'h0);
            step(3);
        end
        chk("gated_level", 32'(level), 15);
        en = 1'b1;
        tick_exp(1'b1, 16'h0002);
        chk("ungated_level", 32'(level), 14);

        for (int i = 3; i <= 16; i++) begin
            step(3);
            tick_exp(1'b1, 16'(i));
        end
        chk("drained_level", 32'(level), 0);
        chk("drained_underrun", 32'(underrun_cnt), 0);
        chk("drained_running", 32'(running), 1);

        // Underrun
        step(3);
        tick_exp(1'b1, ZF ? 16'h0000 : 16'h0010);
        chk("underrun_cnt1", 32'(underrun_cnt), 1);
        chk("underrun_running", 32'(running), 0);
        repeat (2) begin
            step(3);
            tick_exp(1'b0, 16'h0);
        end
        chk("underrun_cnt_hold", 32'(underrun_cnt), 1);

        // Re-prime and drain
        for (int i = 0; i < 8; i++) push(16'(16'h0101 + i));
        step(1);
        chk("reprime_running", 32'(running), 1);
        for (int i = 0; i < 8; i++) begin
            step(3);
            tick_exp(1'b1, 16'(16'h0101 + i));
        end
        chk("reprime_drained", 32'(level), 0);

        // Push into empty FIFO with a tick: underrun, sample stays
        s_data  = 16'h0200;
        s_valid = 1'b1;
        tick_exp(1'b1, ZF ? 16'h0000 : 16'h0108);
        s_valid = 1'b0;
        chk("push_tick_underrun", 32'(underrun_cnt), 2);
        chk("push_tick_level", 32'(level), 1);
        chk("push_tick_running", 32'(running), 0);

        // Reset mid-run with a tick pending
        for (int i = 1; i <= 9; i++) push(16'(16'h0300 + i));
        step(1);
        chk("pre_rst_running", 32'(running), 1);
        chk("pre_rst_level", 32'(level), 10);
        rst  = 1'b1;
        tick = 1'b1;
        step(1);
        rst  = 1'b0;
        tick = 1'b0;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        chk("mid_rst_strobe", 32'(m_strobe), 0);
        chk("mid_rst_underrun", 32'(underrun_cnt), 0);
        chk("mid_rst_running", 32'(running), 0);
        step(5);
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_running", 32'(running), 0);

        step(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
